// File: rtl/dbg_display_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dbg_display_pkg
// Description : Shared constants and the hex-to-7-segment decoder used by the
//               debug display multiplexer.
//               SEG_BLANK - all segments (and DP) off, active-low
//               CNT_W     - width of the optional event counters
//               hex_to_seg - nibble -> active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         CNT_W     = 16;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage : dbg_display_pkg
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretcher
// Description : Retriggerable pulse stretcher. A one-cycle evt pulse keeps
//               led high for STRETCH_CYC clocks, starting one clock after the
//               pulse. A pulse while active restarts the on-time. clr forces
//               the stretcher idle and wins over a simultaneous pulse.
// Ports       : clk_sys - system clock
//               rst     - asynchronous active-high reset
//               evt     - single-cycle event pulse
//               clr     - synchronous clear
//               led     - stretched, registered event indication
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher
  import dbg_display_pkg::*;
#(
  parameter int STRETCH_CYC = 10000000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic evt,
  input  logic clr,
  output logic led
);

  localparam int            CW     = $clog2(STRETCH_CYC + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_CYC);

  generate
    if (STRETCH_CYC < 1) begin : g_err_stretch
      $error("pulse_stretcher: STRETCH_CYC must be at least 1");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_led;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (evt) begin
      w_cnt_nxt = RELOAD;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // led is registered from the next count so it tracks (count != 0) exactly,
  // rising on the edge that samples the pulse.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_led <= (w_cnt_nxt != '0);
    end
  end

  assign led = r_led;

endmodule : pulse_stretcher
`default_nettype wire

// File: rtl/dbg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : dbg_display_mux
// Description : Debug display and event monitor. Shows one of NUM_CH 32-bit
//               debug words in hex on a time-multiplexed 7-segment display
//               (DP marks the selected channel number) and stretches
//               single-cycle event pulses onto LEDs.
//               Optional feature macro: DBG_EVT_CNT_EN - adds per-event 16-bit
//               saturating counters that can be shown instead of a channel
//               when show_cnt is set at snapshot load.
// Ports       : clk_sys  - system clock
//               rst      - asynchronous active-high reset
//               ch_data  - packed debug words, channel k = [32k+31:32k]
//               ch_sel   - channel select
//               freeze   - hold the current snapshot
//               evt_in   - single-cycle event pulses
//               evt_clr  - synchronous clear of stretchers and counters
//               show_cnt - show event counter (optional feature only)
//               cathodes - active-low segments, [7]=DP, [6:0]=g..a
//               AN       - active-low digit enables
//               led      - stretched events
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_display_mux
  import dbg_display_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int SCAN_HZ     = 1000,
  parameter int NUM_CH      = 4,
  parameter int DIGITS      = 8,
  parameter int EVT_W       = 8,
  parameter int STRETCH_CYC = 10000000
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic [NUM_CH*32-1:0]       ch_data,
  input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
  input  logic                       freeze,
  input  logic [EVT_W-1:0]           evt_in,
  input  logic                       evt_clr,
  input  logic                       show_cnt,
  output logic [7:0]                 cathodes,
  output logic [DIGITS-1:0]          AN,
  output logic [EVT_W-1:0]           led
);

  localparam int SCAN_DIV = CLK_FREQ_HZ / (SCAN_HZ * DIGITS);
  localparam int PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SEL_W    = $clog2(NUM_CH);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  generate
    if (SCAN_DIV < 1) begin : g_err_scan_div
      $error("dbg_display_mux: CLK_FREQ_HZ/(SCAN_HZ*DIGITS) must be at least 1");
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_err_num_ch
      $error("dbg_display_mux: NUM_CH must be in 2..16");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_err_digits
      $error("dbg_display_mux: DIGITS must be in 1..8");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Scan prescaler and digit index
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0] r_pre;
  logic [DIG_W-1:0] r_digit;
  logic [DIG_W-1:0] w_digit_nxt;
  logic             w_tick;
  logic             w_load;

  assign w_tick      = (r_pre == PRE_LAST);
  assign w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
  // Snapshot refresh only on the wrap to digit 0 so a whole frame is coherent.
  assign w_load      = w_tick && (r_digit == DIG_LAST) && !freeze;

  // --------------------------------------------------------------------------
  // Source word for the snapshot
  // --------------------------------------------------------------------------
  logic [31:0] w_ch_word;
  logic [31:0] w_load_word;
  logic        w_load_cnt;

  assign w_ch_word = 32'(ch_data >> {ch_sel, 5'b00000});

`ifdef DBG_EVT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [EVT_W];
  logic [CNT_W-1:0] w_cnt_pick;
  logic [7:0]       w_cnt_idx;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < EVT_W; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < EVT_W; k++) begin
        if (evt_clr) begin
          r_cnt[k] <= '0;
        end else if (evt_in[k] && (r_cnt[k] != CNT_MAX)) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Channel select doubles as the event index, folded into range.
  assign w_cnt_idx = 8'(32'(ch_sel) % EVT_W);

  always_comb begin
    w_cnt_pick = '0;
    for (int k = 0; k < EVT_W; k++) begin
      if (w_cnt_idx == 8'(k)) begin
        w_cnt_pick = r_cnt[k];
      end
    end
  end

  assign w_load_cnt  = show_cnt;
  assign w_load_word = show_cnt ? {w_cnt_idx, 8'h00, w_cnt_pick} : w_ch_word;
`else
  logic w_unused_show_cnt;
  assign w_unused_show_cnt = show_cnt;
  assign w_load_cnt        = 1'b0;
  assign w_load_word       = w_ch_word;
`endif

  // --------------------------------------------------------------------------
  // Snapshot registers and display outputs
  // --------------------------------------------------------------------------
  logic [31:0]       r_snap;
  logic [SEL_W-1:0]  r_snap_sel;
  logic              r_snap_cnt;
  logic [31:0]       w_snap_nxt;
  logic [SEL_W-1:0]  w_snap_sel_nxt;
  logic              w_snap_cnt_nxt;
  logic [3:0]        w_nib;
  logic              w_dp_on;
  logic [7:0]        r_cathodes;
  logic [DIGITS-1:0] r_an;

  assign w_snap_nxt     = w_load ? w_load_word : r_snap;
  assign w_snap_sel_nxt = w_load ? ch_sel      : r_snap_sel;
  assign w_snap_cnt_nxt = w_load ? w_load_cnt  : r_snap_cnt;

  // Outputs are computed from the post-tick digit/snapshot so they change on
  // the same edge as the index, i.e. in the cycle after scan_tick.
  assign w_nib   = 4'(w_snap_nxt >> {w_digit_nxt, 2'b00});
  assign w_dp_on = !w_snap_cnt_nxt && (32'(w_digit_nxt) == 32'(w_snap_sel_nxt));

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_pre      <= '0;
      r_digit    <= DIG_LAST;
      r_snap     <= '0;
      r_snap_sel <= '0;
      r_snap_cnt <= 1'b0;
      r_an       <= '1;
      r_cathodes <= SEG_BLANK;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_digit    <= w_digit_nxt;
        r_snap     <= w_snap_nxt;
        r_snap_sel <= w_snap_sel_nxt;
        r_snap_cnt <= w_snap_cnt_nxt;
        r_an       <= ~(DIGITS'(1) << w_digit_nxt);
        r_cathodes <= {~w_dp_on, hex_to_seg(w_nib)};
      end
    end
  end

  assign AN       = r_an;
  assign cathodes = r_cathodes;

  // --------------------------------------------------------------------------
  // Event stretchers
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < EVT_W; g++) begin : g_evt
      pulse_stretcher #(
        .STRETCH_CYC (STRETCH_CYC)
      ) u_stretch (
        .clk_sys (clk_sys),
        .rst     (rst),
        .evt     (evt_in[g]),
        .clr     (evt_clr),
        .led     (led[g])
      );
    end
  endgenerate

endmodule : dbg_display_mux
`default_nettype wire

// File: tb/tb_dbg_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbg_display_mux
// Description : Self-checking bench for dbg_display_mux. A behavioural model
//               derived from edge counts since reset predicts AN, cathodes and
//               led every cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_display_mux;

  localparam int CLK_FREQ_HZ = 800;
  localparam int SCAN_HZ     = 10;
  localparam int NUM_CH      = 4;
  localparam int DIGITS      = 8;
  localparam int EVT_W       = 8;
  localparam int STRETCH_CYC = 5;
  localparam int SCAN_DIV    = CLK_FREQ_HZ / (SCAN_HZ * DIGITS);
`ifdef DBG_EVT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk_sys = 1'b0;
  logic                 rst;
  logic [NUM_CH*32-1:0] ch_data;
  logic [1:0]           ch_sel;
  logic                 freeze;
  logic [EVT_W-1:0]     evt_in;
  logic                 evt_clr;
  logic                 show_cnt;
  logic [7:0]           cathodes;
  logic [DIGITS-1:0]    AN;
  logic [EVT_W-1:0]     led;

  dbg_display_mux #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .SCAN_HZ     (SCAN_HZ),
    .NUM_CH      (NUM_CH),
    .DIGITS      (DIGITS),
    .EVT_W       (EVT_W),
    .STRETCH_CYC (STRETCH_CYC)
  ) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .ch_data  (ch_data),
    .ch_sel   (ch_sel),
    .freeze   (freeze),
    .evt_in   (evt_in),
    .evt_clr  (evt_clr),
    .show_cnt (show_cnt),
    .cathodes (cathodes),
    .AN       (AN),
    .led      (led)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Active-low {g..a} for hex digits 0..F.
  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: everything follows from the number of clock edges
  // since reset release. A tick happens every SCAN_DIV edges; tick n shows
  // digit (n-1) mod DIGITS; the snapshot refreshes on digit 0 unless frozen.
  // An event keeps its LED on for STRETCH_CYC samples after the pulse edge.
  // --------------------------------------------------------------------------
  int unsigned ecount;
  logic [31:0] m_snap;
  int          m_sel;
  bit          m_cmode;
  logic [7:0]  m_an;
  logic [7:0]  m_cath;
  bit          m_lpv [EVT_W];
  int unsigned m_lp  [EVT_W];
  int unsigned m_cnt [EVT_W];
  int          m_n, m_d, m_e;
  logic [127:0] m_sh;
  logic [3:0]  m_nib;

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ecount  = 0;
      m_snap  = '0;
      m_sel   = 0;
      m_cmode = 1'b0;
      m_an    = 8'hFF;
      m_cath  = 8'hFF;
      for (int b = 0; b < EVT_W; b++) begin
        m_lpv[b] = 1'b0;
        m_lp[b]  = 0;
        m_cnt[b] = 0;
      end
    end else begin
      ecount++;
      if (ecount % SCAN_DIV == 0) begin
        m_n = int'(ecount / SCAN_DIV);
        m_d = (m_n - 1) % DIGITS;
        if (m_d == 0 && !freeze) begin
          m_sel = int'(ch_sel);
          if (CNT_EN && show_cnt) begin
            m_e     = m_sel % EVT_W;
            m_snap  = {8'(m_e), 8'h00, 16'(m_cnt[m_e])};
            m_cmode = 1'b1;
          end else begin
            m_sh    = ch_data >> (32 * m_sel);
            m_snap  = m_sh[31:0];
            m_cmode = 1'b0;
          end
        end
        m_an   = ~(8'd1 << m_d);
        m_nib  = 4'(m_snap >> (4 * m_d));
        m_cath = {(!m_cmode && m_d == m_sel) ? 1'b0 : 1'b1, seg_ref[m_nib]};
      end
      for (int b = 0; b < EVT_W; b++) begin
        if (evt_clr) begin
          m_lpv[b] = 1'b0;
          m_cnt[b] = 0;
        end else if (evt_in[b]) begin
          m_lpv[b] = 1'b1;
          m_lp[b]  = ecount;
          if (m_cnt[b] < 65535) m_cnt[b]++;
        end
      end
    end
  end

  // Per-cycle compare, on the falling edge.
  logic [EVT_W-1:0] exp_led;
  always @(negedge clk_sys) begin
    if (rst) begin
      check8("rst_an", AN, 8'hFF);
      check8("rst_cathodes", cathodes, 8'hFF);
      check8("rst_led", led, 8'h00);
    end else begin
      for (int b = 0; b < EVT_W; b++) begin
        exp_led[b] = m_lpv[b] && ((ecount - m_lp[b]) < STRETCH_CYC);
      end
      check8("an", AN, m_an);
      check8("cathodes", cathodes, m_cath);
      check8("led", led, exp_led);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic goto_edge(input int target);
    int guard;
    guard = 0;
    while (int'(ecount) < target) begin
      step();
      guard++;
      if (guard > 200000) begin
        $display("FAIL goto_edge: timeout waiting for edge %0d at %0d", target, ecount);
        $fatal(1, "timeout");
      end
    end
  endtask

  // First edge after 'from' on which digit d becomes active.
  function automatic int digit_edge(input int from, input int d);
    int w;
    w = from + 1;
    while (!((w % SCAN_DIV) == 0 && (((w / SCAN_DIV) - 1) % DIGITS) == d)) w++;
    return w;
  endfunction

  int cnt_on;
  int wrap_e;

  initial begin
    rst      = 1'b0;
    ch_data  = {32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h1234_ABCD, 32'h5566_7788};
    ch_sel   = 2'd1;
    freeze   = 1'b0;
    evt_in   = '0;
    evt_clr  = 1'b0;
    show_cnt = 1'b0;
    #1 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset / first frame
    goto_edge(9);
    check8("pre_tick_an", AN, 8'hFF);
    check8("pre_tick_cathodes", cathodes, 8'hFF);
    goto_edge(10);
    check8("first_an", AN, 8'hFE);
    check8("first_d0", cathodes, 8'hA1);
    goto_edge(20);
    check8("first_an1", AN, 8'hFD);
    check8("first_d1_dp", cathodes, 8'h46);
    goto_edge(80);
    check8("last_an", AN, 8'h7F);
    goto_edge(90);
    check8("wrap_an", AN, 8'hFE);

    // Mid-frame change is not visible until the wrap
    goto_edge(91);
    ch_data[63:32] = 32'h0F0F_5A5A;
    goto_edge(100);
    check8("midframe_hold", cathodes, 8'h46);
    goto_edge(165);
    freeze = 1'b1;
    goto_edge(170);
    check8("freeze_hold", cathodes, 8'hA1);
    goto_edge(175);
    freeze = 1'b0;
    goto_edge(250);
    check8("unfreeze_new", cathodes, 8'h88);

    // Stretch: single pulse
    goto_edge(300);
    cnt_on = 0;
    evt_in = 8'h08;
    for (int i = 0; i < 10; i++) begin
      step();
      evt_in = '0;
      if (led[3]) cnt_on++;
    end
    check_int("stretch_single", cnt_on, 5);

    // Retrigger 3 cycles later
    cnt_on = 0;
    evt_in = 8'h08;
    for (int i = 0; i < 12; i++) begin
      step();
      evt_in = (i == 2) ? 8'h08 : 8'h00;
      if (led[3]) cnt_on++;
    end
    check_int("stretch_retrig", cnt_on, 8);

    // Clear wins over a simultaneous pulse
    cnt_on = 0;
    evt_in  = 8'h08;
    evt_clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      evt_in  = '0;
      evt_clr = 1'b0;
      if (led[3]) cnt_on++;
    end
    check_int("stretch_clr", cnt_on, 0);

    // Asynchronous reset while digit 4 is lit
    goto_edge(digit_edge(int'(ecount), 4) + 3);
    check8("digit4_an", AN, 8'hEF);
    #2 rst = 1'b1;
    #1;
    check8("async_an", AN, 8'hFF);
    check8("async_cathodes", cathodes, 8'hFF);
    step();
    step();
    rst = 1'b0;
    goto_edge(10);
    check8("restart_an", AN, 8'hFE);
    check8("restart_d0", cathodes, 8'h88);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      ch_data  = {$urandom, $urandom, $urandom, $urandom};
      ch_sel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      evt_in   = 8'($urandom & $urandom & $urandom);
      evt_clr  = ($urandom_range(0, 31) == 0);
      show_cnt = 1'($urandom_range(0, 1));
      step();
    end
    freeze   = 1'b0;
    evt_in   = '0;
    evt_clr  = 1'b0;
    show_cnt = 1'b0;

`ifdef DBG_EVT_CNT_EN
    // Counter saturation and display
    ch_sel = 2'd2;
    evt_in = 8'h04;
    repeat (70000) step();
    evt_in   = '0;
    show_cnt = 1'b1;
    wrap_e = digit_edge(int'(ecount), 0);
    goto_edge(wrap_e);
    check8("cnt_sat_d0", cathodes, 8'h8E);
    goto_edge(wrap_e + 60);
    check8("cnt_sat_d6", cathodes, 8'hA4);
    goto_edge(wrap_e + 70);
    check8("cnt_sat_d7", cathodes, 8'hC0);
    evt_clr = 1'b1;
    step();
    evt_clr = 1'b0;
    goto_edge(wrap_e + 80);
    check8("cnt_clr_d0", cathodes, 8'hC0);
    goto_edge(wrap_e + 140);
    check8("cnt_clr_d6", cathodes, 8'hA4);
`endif

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dbg_display_mux
`default_nettype wire
